// File: rtl/shift_issue_ctrl.sv
// shift_issue_ctrl: issues one shifter operation per request and captures its result and flags.
module shift_issue_ctrl #(
  parameter int SETUP_CYCLES  = 1,
  parameter int PULSE_CYCLES  = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_data,
  input  logic [1:0] req_opcode,
  input  logic [2:0] req_count,
  input  logic       req_src_acc,
  input  logic       req_upd_flags,
  output logic [7:0] sh_data,
  output logic [1:0] sh_opcode,
  output logic [2:0] sh_count,
  output logic       shift_enable,
  input  logic [7:0] shift_out,
  input  logic       sh_z,
  input  logic       sh_c,
  output logic [7:0] acc,
  output logic       flag_z,
  output logic       flag_c,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, SETTLE, DONE} state_t;
  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic upd, last, accept, capture;
  always_comb begin
    last = state == SETUP ? cnt == 8'(SETUP_CYCLES - 1) :
           state == PULSE ? cnt == 8'(PULSE_CYCLES - 1) :
                            cnt == 8'(SETTLE_CYCLES - 1);
    accept = state == IDLE && req_valid;
    capture = state == SETTLE && last;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = req_valid ? SETUP : IDLE;
      SETUP:   state_nxt = last ? PULSE : SETUP;
      PULSE:   state_nxt = last ? SETTLE : PULSE;
      SETTLE:  state_nxt = last ? DONE : SETTLE;
      default: state_nxt = IDLE;
    endcase
    cnt_nxt = (state_nxt != state || state == IDLE) ? 8'd0 : cnt + 8'd1;
  end
  // ready is gated by rst so it reads low during an asserted async reset
  assign req_ready = state == IDLE && !rst;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 8'd0;
      shift_enable <= 1'b0;
      sh_data <= 8'd0;
      sh_opcode <= 2'd0;
      sh_count <= 3'd0;
      upd <= 1'b0;
      acc <= 8'd0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      shift_enable <= state_nxt == PULSE;
      if (accept) begin
        sh_data <= req_src_acc ? acc : req_data;
        sh_opcode <= req_opcode;
        sh_count <= req_count;
        upd <= req_upd_flags;
      end
      if (capture) begin
        acc <= shift_out;
        if (upd) begin
          flag_z <= sh_z;
          flag_c <= sh_c;
        end
      end
    end
  end
endmodule

// File: tb/tb_shift_issue_ctrl.sv
// tb_shift_issue_ctrl: directed vector bench with a behavioural shifter answering each DUT.
module tb_shift_issue_ctrl;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic req_valid = 0, req_ready, req_src_acc = 0, req_upd_flags = 0;
  logic [7:0] req_data = 0, sh_data, shift_out = 0, acc;
  logic [1:0] req_opcode = 0, sh_opcode;
  logic [2:0] req_count = 0, sh_count;
  logic shift_enable, sh_z = 0, sh_c = 0, flag_z, flag_c, busy, done;

  logic b_valid = 0, b_ready, b_src = 0, b_upd = 0;
  logic [7:0] b_data = 0, b_sh_data, b_out = 0, b_acc;
  logic [1:0] b_op = 0, b_sh_op;
  logic [2:0] b_cnt = 0, b_sh_cnt;
  logic b_se, b_z = 0, b_c = 0, b_fz, b_fc, b_busy, b_done;

  int errors = 0, checks = 0;

  shift_issue_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_opcode(req_opcode), .req_count(req_count),
    .req_src_acc(req_src_acc), .req_upd_flags(req_upd_flags),
    .sh_data(sh_data), .sh_opcode(sh_opcode), .sh_count(sh_count),
    .shift_enable(shift_enable), .shift_out(shift_out), .sh_z(sh_z), .sh_c(sh_c),
    .acc(acc), .flag_z(flag_z), .flag_c(flag_c), .busy(busy), .done(done));

  shift_issue_ctrl #(.SETUP_CYCLES(2), .PULSE_CYCLES(3), .SETTLE_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_data(b_data), .req_opcode(b_op), .req_count(b_cnt),
    .req_src_acc(b_src), .req_upd_flags(b_upd),
    .sh_data(b_sh_data), .sh_opcode(b_sh_op), .sh_count(b_sh_cnt),
    .shift_enable(b_se), .shift_out(b_out), .sh_z(b_z), .sh_c(b_c),
    .acc(b_acc), .flag_z(b_fz), .flag_c(b_fc), .busy(b_busy), .done(b_done));

  // opcodes: 0 SHL, 1 SHR, 2 ROL, 3 ROR; result {z, c, data}
  function automatic logic [9:0] shf(input logic [7:0] d, input logic [1:0] op, input logic [2:0] n);
    logic [15:0] dd;
    logic [7:0] r;
    logic c;
    int k;
    k = int'(n);
    dd = {d, d};
    c = 1'b0;
    case (op)
      2'd0: begin r = d << n; if (k > 0) c = d[8 - k]; end
      2'd1: begin r = d >> n; if (k > 0) c = d[k - 1]; end
      2'd2: begin dd = dd << n; r = dd[15:8]; end
      default: begin dd = dd >> n; r = dd[7:0]; end
    endcase
    return {r == 8'd0, c, r};
  endfunction

  always @(posedge shift_enable) {sh_z, sh_c, shift_out} <= shf(sh_data, sh_opcode, sh_count);
  always @(posedge b_se) {b_z, b_c, b_out} <= shf(b_sh_data, b_sh_op, b_sh_cnt);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [2:0] n;
    logic src, upd;
    logic [7:0] ex_sh, ex_acc;
    logic ex_z, ex_c;
  } vec_t;

  task automatic issue(input vec_t t, input string nm);
    int lat, rises, w;
    logic prev, stable;
    @(negedge clk);
    req_opcode = t.op; req_data = t.data; req_count = t.n;
    req_src_acc = t.src; req_upd_flags = t.upd; req_valid = 1;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) chk({nm, "_accept_timeout"}, 0, 1);
    @(posedge clk);
    #1 req_valid = 0; req_data = 8'h5A; req_opcode = ~t.op; req_count = ~t.n;
    lat = 0; rises = 0; prev = 0; stable = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (shift_enable && !prev) rises++;
      prev = shift_enable;
      if (sh_data !== t.ex_sh || sh_opcode !== t.op || sh_count !== t.n) stable = 0;
      if (done) begin lat = k; break; end
    end
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_pulses"}, rises, 1);
    chk({nm, "_operands"}, stable, 1);
    chk({nm, "_acc"}, acc, t.ex_acc);
    chk({nm, "_z"}, flag_z, t.ex_z);
    chk({nm, "_c"}, flag_c, t.ex_c);
    @(negedge clk);
    chk({nm, "_ready_after"}, req_ready, 1);
  endtask

  vec_t v[7];
  int acc_n, at0, at1, w, dn, hi, rs, lat;
  logic prev;

  initial begin
    v[0] = '{2'd0, 8'h81, 3'd1, 1'b0, 1'b1, 8'h81, 8'h02, 1'b0, 1'b1};
    v[1] = '{2'd1, 8'h01, 3'd1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b1, 1'b1};
    v[2] = '{2'd2, 8'h80, 3'd1, 1'b0, 1'b0, 8'h80, 8'h01, 1'b1, 1'b1};
    v[3] = '{2'd3, 8'h0F, 3'd4, 1'b0, 1'b1, 8'h0F, 8'hF0, 1'b0, 1'b0};
    v[4] = '{2'd0, 8'hFF, 3'd3, 1'b1, 1'b1, 8'hF0, 8'h80, 1'b0, 1'b1};
    v[5] = '{2'd1, 8'h80, 3'd7, 1'b0, 1'b1, 8'h80, 8'h01, 1'b0, 1'b0};
    v[6] = '{2'd2, 8'h01, 3'd7, 1'b0, 1'b0, 8'h01, 8'h80, 1'b0, 1'b0};

    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_se", shift_enable, 0);
    chk("rst_acc", acc, 0);
    @(negedge clk); rst = 0;
    #1 chk("post_rst_ready", req_ready, 1);

    for (int i = 0; i < 7; i++) issue(v[i], $sformatf("vec%0d", i));

    // request held valid: accepts only on each return to IDLE
    @(negedge clk);
    req_opcode = 0; req_data = 8'hA5; req_count = 0; req_src_acc = 0; req_upd_flags = 1; req_valid = 1;
    acc_n = 0; at0 = -1; at1 = -1;
    for (int k = 0; k < 10; k++) begin
      if (req_ready) begin
        if (acc_n == 0) at0 = k; else at1 = k;
        acc_n++;
      end
      @(negedge clk);
    end
    req_valid = 0;
    chk("hold_accepts", acc_n, 2);
    chk("hold_gap", at1 - at0, 5);
    w = 0;
    while (busy && w < 20) begin @(negedge clk); w++; end
    chk("hold_idle", busy, 0);
    chk("hold_acc", acc, 8'hA5);
    chk("hold_c", flag_c, 0);
    chk("hold_z", flag_z, 0);

    // reset asserted while shift_enable is high
    @(negedge clk);
    req_opcode = 0; req_data = 8'h81; req_count = 1; req_upd_flags = 1; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    w = 0;
    while (!shift_enable && w < 10) begin @(posedge clk); #1; w++; end
    chk("mid_se_seen", shift_enable, 1);
    #2 rst = 1;
    #1;
    chk("mid_se", shift_enable, 0);
    chk("mid_busy", busy, 0);
    chk("mid_acc", acc, 0);
    chk("mid_ready", req_ready, 0);
    @(negedge clk); rst = 0;
    #1 chk("mid_ready_rel", req_ready, 1);
    dn = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (done) dn++; end
    chk("mid_no_done", dn, 0);
    chk("mid_acc_hold", acc, 0);
    issue(v[0], "post_rst");

    // stretched timing on the second instance
    @(negedge clk);
    b_op = 0; b_data = 8'h81; b_cnt = 1; b_src = 0; b_upd = 1; b_valid = 1;
    chk("b_ready", b_ready, 1);
    @(posedge clk);
    #1 b_valid = 0;
    hi = 0; rs = 0; lat = 0; prev = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (b_se) hi++;
      if (b_se && !prev) rs++;
      prev = b_se;
      if (b_done) begin lat = k; break; end
    end
    chk("b_se_high", hi, 3);
    chk("b_pulses", rs, 1);
    chk("b_latency", lat, 8);
    chk("b_acc", b_acc, 8'h02);
    chk("b_c", b_fc, 1);
    chk("b_z", b_fz, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
